mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

- Sits directly downstream of the CPU core, on its 8-bit shared bus.
- Turns CPU address/data beats into one request/acknowledge transaction per access on a single memory port, steering it to ROM or RAM.
- Returns read data to the core with a single-cycle ready pulse.
- Optionally bounds each access with a timeout so a missing acknowledge cannot hang the core.

## Interface
Parameters:
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack (1..255); used only with timeout enabled

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- cpu_bus  input  8  address (address beat) or write data (data beat)
- cpu_valid  input  1  beat present this cycle
- cpu_addr_data  input  1  1 = address beat, 0 = data beat
- cpu_rom_ram  input  1  0 = ROM, 1 = RAM; sampled on address beat
- cpu_we  input  1  1 = write; sampled on address beat
- cpu_rdata  output  8  read data, valid while cpu_ready
- cpu_ready  output  1  one-cycle pulse: transaction complete
- mem_req  output  1  request, held until acknowledged
- mem_sel  output  1  0 = ROM, 1 = RAM
- mem_we  output  1  write strobe qualifier
- mem_addr  output  8  latched address
- mem_wdata  output  8  latched write data
- mem_ack  input  1  memory accepted/completed request
- mem_rdata  input  8  read data, valid with mem_ack
- bus_err  output  1  one-cycle error pulse

## Operation
- All outputs registered.
- Reset values: all outputs 0; state IDLE.
- Beats are sampled only when cpu_valid=1.
- IDLE, address beat:
  - latch mem_addr=cpu_bus, mem_sel=cpu_rom_ram, mem_we=cpu_we.
  - read → REQ.
  - write → WDATA.
- IDLE, data beat: ignored; bus_err pulses.
- WDATA:
  - data beat: latch mem_wdata.
    - RAM → REQ.
    - ROM write → IDLE, no mem_req, bus_err and cpu_ready pulse together.
  - address beat: ignored, bus_err pulses.
- REQ:
  - mem_req=1, and addr/sel/we/wdata held stable until mem_ack is sampled high.
  - On mem_ack: mem_req=0 next cycle.
    - read: cpu_rdata=mem_rdata.
    - write: cpu_rdata unchanged.
  - Then cpu_ready pulses one cycle (RESP), and the state returns to IDLE.
- Beats arriving in REQ/RESP: ignored, no error; the core must wait for cpu_ready.
- mem_ack while mem_req=0: ignored.
- Reset mid-transaction: mem_req drops at the reset edge; a late mem_ack is ignored.

## Timing
- Read, address beat sampled at edge 0:
  - mem_req high after edge 0.
  - zero-wait ack sampled at edge 1.
  - cpu_ready/cpu_rdata valid after edge 1.
  - Minimum: 2 cycles address-to-ready.
- Each memory wait cycle adds one cycle.
- Write: mem_req high the cycle after the data beat; ready the cycle after ack. Minimum 3 cycles from address beat when the data beat immediately follows.
- Back-to-back: a new address beat is accepted in the cycle cpu_ready is high (state already IDLE).
- cpu_ready and bus_err are exactly one cycle wide.

## Configuration
- MEM_BUS_TIMEOUT_EN defined:
  - the counter increments each REQ cycle without ack.
  - on reaching TIMEOUT, mem_req drops, cpu_rdata=8'hFF (reads), and cpu_ready and bus_err pulse together.
  - An ack in the same cycle as expiry wins: normal completion, no error.
- Undefined:
  - no counter; REQ waits indefinitely.
  - bus_err still reports protocol errors.

## Structure
- Package mem_bus_pkg:
  - state enum {IDLE, WDATA, REQ, RESP}.
  - constants SEL_ROM=0, SEL_RAM=1.
  - RDATA_ERR=8'hFF.
- Sub-module mem_bus_timeout:
  - counter with clear/enable/expire.
  - instantiated only under MEM_BUS_TIMEOUT_EN.

## Test plan
- ROM read addr 8'h10, ack same cycle with rdata 8'hA5 → mem_req one cycle; cpu_ready after 2 cycles, cpu_rdata=8'hA5; bus_err=0.
- RAM write addr 8'h20, data 8'h3C, ack after 3 waits → mem_sel=1, mem_we=1, mem_wdata=8'h3C stable over 4 req cycles; single cpu_ready.
- ROM write addr 8'h05 → no mem_req; cpu_ready+bus_err pulse after the data beat.
- Data beat in IDLE, then address beat during REQ → bus_err on the first only; second ignored; mem_addr unchanged.
- Timeout enabled, TIMEOUT=4, no ack → mem_req high exactly 4 cycles; cpu_rdata=8'hFF with cpu_ready+bus_err. Ack on the 4th cycle → normal data, no error.
- Reset asserted during REQ, then ack → mem_req=0 after reset; no cpu_ready.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, bus select constants and error read data for mem_bus_ctrl
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, WDATA, REQ, RESP} state_t;
  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;
  localparam logic [7:0] RDATA_ERR = 8'hFF;
endpackage

// File: rtl/mem_bus_timeout.sv
// mem_bus_timeout: request wait counter; expire is high in the REQ cycle that would be the TIMEOUT-th without ack
// Ports: clk, reset (sync, active-high), clear (restart count), enable (count this cycle), expire (limit reached)
module mem_bus_timeout
  #(parameter int TIMEOUT = 15)
  (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  assign expire = enable && (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns CPU address/data beats into one req/ack transaction on a ROM/RAM memory port
// Ports: clk, reset (sync, active-high); CPU side cpu_bus/cpu_valid/cpu_addr_data/cpu_rom_ram/cpu_we in,
//   cpu_rdata/cpu_ready out; memory side mem_req/mem_sel/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in;
//   bus_err pulses on protocol errors or timeout. Define MEM_BUS_TIMEOUT_EN to bound REQ by TIMEOUT cycles.
module mem_bus_ctrl
  import mem_bus_pkg::*;
  #(parameter int TIMEOUT = 15)
  (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_bus,
  input  logic       cpu_valid,
  input  logic       cpu_addr_data,
  input  logic       cpu_rom_ram,
  input  logic       cpu_we,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       bus_err
);
  state_t state, state_n;
  logic [7:0] cpu_rdata_n, mem_addr_n, mem_wdata_n;
  logic cpu_ready_n, mem_req_n, mem_sel_n, mem_we_n, bus_err_n, expired;
`ifdef MEM_BUS_TIMEOUT_EN
  mem_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clear(state != REQ),
    .enable(state == REQ && !mem_ack),
    .expire(expired)
  );
`else
  // No timeout: REQ waits for mem_ack indefinitely (TIMEOUT is always >= 1, so this is constant 0).
  assign expired = 1'b0 & (TIMEOUT == 0);
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_sel   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cpu_rdata <= cpu_rdata_n;
      cpu_ready <= cpu_ready_n;
      mem_req   <= mem_req_n;
      mem_sel   <= mem_sel_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      bus_err   <= bus_err_n;
    end
  // Completion goes straight back to IDLE so a new address beat is accepted while cpu_ready is high.
  always_comb begin
    state_n     = state;
    cpu_rdata_n = cpu_rdata;
    cpu_ready_n = 1'b0;
    mem_req_n   = mem_req;
    mem_sel_n   = mem_sel;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    bus_err_n   = 1'b0;
    case (state)
      IDLE:
        if (cpu_valid && cpu_addr_data) begin
          mem_addr_n = cpu_bus;
          mem_sel_n  = cpu_rom_ram;
          mem_we_n   = cpu_we;
          state_n    = cpu_we ? WDATA : REQ;
          mem_req_n  = !cpu_we;
        end else if (cpu_valid) bus_err_n = 1'b1;
      WDATA:
        if (cpu_valid && !cpu_addr_data) begin
          mem_wdata_n = cpu_bus;
          state_n     = (mem_sel == SEL_RAM) ? REQ : IDLE;
          mem_req_n   = (mem_sel == SEL_RAM);
          cpu_ready_n = (mem_sel == SEL_ROM);
          bus_err_n   = (mem_sel == SEL_ROM);
        end else if (cpu_valid) bus_err_n = 1'b1;
      REQ:
        if (mem_ack || expired) begin
          mem_req_n   = 1'b0;
          cpu_rdata_n = mem_we ? cpu_rdata : (mem_ack ? mem_rdata : RDATA_ERR);
          cpu_ready_n = 1'b1;
          bus_err_n   = !mem_ack;
          state_n     = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 15;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] cpu_bus = '0, mem_rdata = '0;
  logic cpu_valid = 1'b0, cpu_addr_data = 1'b0, cpu_rom_ram = 1'b0, cpu_we = 1'b0, mem_ack = 1'b0;
  logic [7:0] cpu_rdata, mem_addr, mem_wdata;
  logic cpu_ready, mem_req, mem_sel, mem_we, bus_err;
  int checks = 0, errors = 0;

  mem_bus_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cpu_bus(cpu_bus), .cpu_valid(cpu_valid),
    .cpu_addr_data(cpu_addr_data), .cpu_rom_ram(cpu_rom_ram), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_req(mem_req), .mem_sel(mem_sel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic ad, input logic [7:0] b, input logic rr, input logic we);
    cpu_valid = 1'b1; cpu_addr_data = ad; cpu_bus = b; cpu_rom_ram = rr; cpu_we = we;
    tick();
    cpu_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_req", {7'd0, mem_req}, 8'd0);
    chk("rst_ready", {7'd0, cpu_ready}, 8'd0);
    chk("rst_err", {7'd0, bus_err}, 8'd0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_addr", mem_addr, 8'h00);
    // ROM read, zero-wait ack
    beat(1'b1, 8'h10, 1'b0, 1'b0);
    chk("rd_req", {7'd0, mem_req}, 8'd1);
    chk("rd_addr", mem_addr, 8'h10);
    chk("rd_sel", {7'd0, mem_sel}, 8'd0);
    chk("rd_ready_early", {7'd0, cpu_ready}, 8'd0);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    chk("rd_req_drop", {7'd0, mem_req}, 8'd0);
    chk("rd_ready", {7'd0, cpu_ready}, 8'd1);
    chk("rd_rdata", cpu_rdata, 8'hA5);
    chk("rd_err", {7'd0, bus_err}, 8'd0);
    tick();
    chk("rd_ready_pulse", {7'd0, cpu_ready}, 8'd0);
    // RAM write with 3 wait cycles
    beat(1'b1, 8'h20, 1'b1, 1'b1);
    chk("wr_no_req_yet", {7'd0, mem_req}, 8'd0);
    beat(1'b0, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("wr_req", {7'd0, mem_req}, 8'd1);
      chk("wr_sel", {7'd0, mem_sel}, 8'd1);
      chk("wr_we", {7'd0, mem_we}, 8'd1);
      chk("wr_wdata", mem_wdata, 8'h3C);
      chk("wr_addr", mem_addr, 8'h20);
      chk("wr_ready_early", {7'd0, cpu_ready}, 8'd0);
      if (k == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("wr_req_drop", {7'd0, mem_req}, 8'd0);
    chk("wr_ready", {7'd0, cpu_ready}, 8'd1);
    chk("wr_rdata_kept", cpu_rdata, 8'hA5);
    chk("wr_err", {7'd0, bus_err}, 8'd0);
    tick();
    chk("wr_ready_pulse", {7'd0, cpu_ready}, 8'd0);
    // ROM write is rejected after the data beat
    beat(1'b1, 8'h05, 1'b0, 1'b1);
    beat(1'b0, 8'h77, 1'b0, 1'b0);
    chk("romwr_req", {7'd0, mem_req}, 8'd0);
    chk("romwr_ready", {7'd0, cpu_ready}, 8'd1);
    chk("romwr_err", {7'd0, bus_err}, 8'd1);
    tick();
    chk("romwr_ready_pulse", {7'd0, cpu_ready}, 8'd0);
    chk("romwr_err_pulse", {7'd0, bus_err}, 8'd0);
    chk("romwr_req_after", {7'd0, mem_req}, 8'd0);
    // Data beat in IDLE, then address beat during REQ
    beat(1'b0, 8'hEE, 1'b0, 1'b0);
    chk("idle_data_err", {7'd0, bus_err}, 8'd1);
    chk("idle_data_req", {7'd0, mem_req}, 8'd0);
    tick();
    chk("idle_data_err_pulse", {7'd0, bus_err}, 8'd0);
    beat(1'b1, 8'h42, 1'b1, 1'b0);
    chk("req2_addr", mem_addr, 8'h42);
    beat(1'b1, 8'h99, 1'b0, 1'b0);
    chk("req_addr_beat_err", {7'd0, bus_err}, 8'd0);
    chk("req_addr_kept", mem_addr, 8'h42);
    chk("req_still", {7'd0, mem_req}, 8'd1);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    chk("req2_ready", {7'd0, cpu_ready}, 8'd1);
    chk("req2_rdata", cpu_rdata, 8'h5A);
    // Back-to-back: address beat accepted while cpu_ready is high
    beat(1'b1, 8'h11, 1'b0, 1'b0);
    chk("b2b_req", {7'd0, mem_req}, 8'd1);
    chk("b2b_addr", mem_addr, 8'h11);
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0;
    chk("b2b_rdata", cpu_rdata, 8'hC3);
    tick();
    // Stray ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_ready", {7'd0, cpu_ready}, 8'd0);
    // Reset during REQ, then late ack
    beat(1'b1, 8'h30, 1'b1, 1'b0);
    chk("rstreq_req", {7'd0, mem_req}, 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstreq_req_drop", {7'd0, mem_req}, 8'd0);
    mem_ack = 1'b1; mem_rdata = 8'h44;
    tick();
    mem_ack = 1'b0;
    chk("rstreq_ready", {7'd0, cpu_ready}, 8'd0);
    chk("rstreq_req_after", {7'd0, mem_req}, 8'd0);
    chk("rstreq_rdata", cpu_rdata, 8'h00);
`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: mem_req high exactly TMO cycles, then error completion
    beat(1'b1, 8'h50, 1'b0, 1'b0);
    for (int k = 0; k < TMO; k++) begin
      chk("tmo_req", {7'd0, mem_req}, 8'd1);
      chk("tmo_ready_early", {7'd0, cpu_ready}, 8'd0);
      tick();
    end
    chk("tmo_req_drop", {7'd0, mem_req}, 8'd0);
    chk("tmo_rdata", cpu_rdata, 8'hFF);
    chk("tmo_ready", {7'd0, cpu_ready}, 8'd1);
    chk("tmo_err", {7'd0, bus_err}, 8'd1);
    tick();
    // Ack on the final allowed cycle wins
    beat(1'b1, 8'h51, 1'b0, 1'b0);
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("tmo_last_req", {7'd0, mem_req}, 8'd1);
    mem_ack = 1'b1; mem_rdata = 8'h66;
    tick();
    mem_ack = 1'b0;
    chk("tmo_ack_ready", {7'd0, cpu_ready}, 8'd1);
    chk("tmo_ack_rdata", cpu_rdata, 8'h66);
    chk("tmo_ack_err", {7'd0, bus_err}, 8'd0);
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
